// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch queue and the IF/ID register.
package pipeline_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_WIDTH = 32;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [FQ_WIDTH-1:0] pc;
        logic [FQ_WIDTH-1:0] instr;
    } fetch_entry;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping pointer counter for the fetch queue.
// Clear wins over increment.
module fq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Pointer wraps naturally at 2**W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with one-cycle flush.
// Presents a NOP when empty.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = FQ_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fq_entry_t;

    fq_entry_t      mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic           push;
    logic           pop;

    // Full/empty come from the occupancy register only.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign out_pc    = out_valid ? mem[rp].pc    : '0;
    assign out_instr = out_valid ? mem[rp].instr : WIDTH'(NOP_INSTR);

    fq_ptr #(.W(AW)) u_wp (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (flush),
        .ptr (wp)
    );

    fq_ptr #(.W(AW)) u_rp (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (flush),
        .ptr (rp)
    );

    // Entry storage; contents are left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // Occupancy: flush clears, push/pop together hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue.
// Directed vectors; monitor checks at each falling edge.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_pc = '0;
    logic [WIDTH-1:0]  in_instr = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_pc;
    logic [WIDTH-1:0]  out_instr;
    logic              out_ready = 1'b0;
    logic [2:0]        count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    int   mcount = 0;
    int   tests = 0;
    int   fails = 0;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge; model decides what the queue accepted.
    task automatic step(output bit acc);
        bit pu;
        bit po;
        @(posedge clk);
        acc = 1'b0;
        if (!rst || flush) begin
            mcount = 0;
            q.delete();
        end else begin
            pu = in_valid && (mcount < DEPTH);
            po = out_ready && (mcount > 0);
            if (pu) q.push_back('{in_pc, in_instr});
            mcount = mcount + int'(pu) - int'(po);
            acc = pu;
        end
        #1;
    endtask

    // Monitor: compare head against scoreboard, pop on model pop.
    always @(negedge clk) begin
        exp_t e;
        check("valid", {31'b0, out_valid}, {31'b0, mcount != 0});
        check("count", {29'b0, count}, mcount);
        check("in_ready", {31'b0, in_ready}, {31'b0, mcount != DEPTH});
        if (mcount == 0) begin
            check("empty_pc", out_pc, 32'h0);
            check("empty_instr", out_instr, 32'h0);
        end else if (q.size() > 0) begin
            e = q[0];
            check("head_pc", out_pc, e.pc);
            check("head_instr", out_instr, e.instr);
            if (rst && out_ready && !flush) void'(q.pop_front());
        end
    end

    initial begin
        bit acc;
        int i;
        int cyc;

        // Reset held for two edges, then released.
        step(acc);
        step(acc);
        rst = 1'b1;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        check("rst_instr", out_instr, 32'h0);

        // Empty pop for 3 cycles.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step(acc);
        check("empty_pop_count", {29'b0, count}, 32'h0);
        check("empty_pop_instr", out_instr, 32'h0);

        // Fill with decode stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_pc    = 32'(k * 4);
            in_instr = 32'h2008_0001 + 32'(k);
            step(acc);
        end
        check("fill_count", {29'b0, count}, 32'h4);
        check("fill_ready", {31'b0, in_ready}, 32'h0);

        // 5th push must be ignored.
        in_pc    = 32'h10;
        in_instr = 32'h2008_0005;
        step(acc);
        check("over_acc", {31'b0, acc}, 32'h0);
        check("over_count", {29'b0, count}, 32'h4);
        check("over_head", out_pc, 32'h0);

        // Drain in order.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step(acc);
        check("drain_count", {29'b0, count}, 32'h0);
        check("drain_instr", out_instr, 32'h0);

        // Simultaneous push/pop at count 2.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_pc    = 32'h40 + 32'(k * 4);
            in_instr = 32'h2409_0000 + 32'(k);
            step(acc);
        end
        out_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            in_pc    = 32'h40 + 32'(k * 4);
            in_instr = 32'h2409_0000 + 32'(k);
            step(acc);
            check("pp_count", {29'b0, count}, 32'h2);
        end
        check("pp_head", out_pc, 32'h4C);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        check("pp_drained", {29'b0, count}, 32'h0);

        // Flush at count 3 with push and pop pending.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_pc    = 32'h80 + 32'(k * 4);
            in_instr = 32'h3c01_0000 + 32'(k);
            step(acc);
        end
        check("pre_flush_count", {29'b0, count}, 32'h3);
        in_pc     = 32'h100;
        in_instr  = 32'hdead_beef;
        out_ready = 1'b1;
        flush     = 1'b1;
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", {29'b0, count}, 32'h0);
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        step(acc);
        step(acc);

        // Wrap-around stream with toggling out_ready.
        i   = 0;
        cyc = 0;
        while (i < 10 && cyc < 100) begin
            in_valid  = 1'b1;
            in_pc     = 32'(i * 4);
            in_instr  = 32'h2000_0000 + 32'(i);
            out_ready = cyc[0];
            step(acc);
            if (acc) i++;
            cyc++;
        end
        check("wrap_sent", i, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step(acc);
        check("wrap_left", q.size(), 0);
        check("wrap_count", {29'b0, count}, 32'h0);

        // Asynchronous reset between edges with 2 words held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_pc    = 32'h200 + 32'(k * 4);
            in_instr = 32'h2008_0010 + 32'(k);
            step(acc);
        end
        in_valid = 1'b0;
        check("pre_rst_count", {29'b0, count}, 32'h2);
        #2;
        rst    = 1'b0;
        mcount = 0;
        q.delete();
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'h0);
        check("arst_instr", out_instr, 32'h0);
        check("arst_count", {29'b0, count}, 32'h0);
        check("arst_ready", {31'b0, in_ready}, 32'h1);
        step(acc);
        rst = 1'b1;
        step(acc);
        check("post_rst_count", {29'b0, count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction-fetch stage and the decode stage of the MIPS pipeline. It buffers up to DEPTH fetched {PC, instruction} pairs, so fetch keeps running while decode stalls. A taken branch resolved downstream flushes all buffered entries in one cycle. When the queue is empty it presents a NOP (32'h0, sll $0,$0,0) to decode.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2
- WIDTH, 32: instruction and PC width in bits

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  drop all entries; driven by taken-branch resolution
- in_valid  in  1  fetch stage presents a word this cycle
- in_pc  in  WIDTH  byte address of the fetched instruction
- in_instr  in  WIDTH  fetched instruction
- in_ready  out  1  queue accepts a word this cycle
- out_valid  out  1  head entry valid
- out_pc  out  WIDTH  head PC, or 0 when empty
- out_instr  out  WIDTH  head instruction, or 32'h0 (NOP) when empty
- out_ready  in  1  decode consumes the head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular array of DEPTH {pc, instr} entries, with write pointer wp, read pointer rp, and occupancy register count.
- Push: in_valid && in_ready && !flush. Writes entry[wp] and advances wp modulo DEPTH.
- Pop: out_valid && out_ready && !flush. Advances rp modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state, so there is no combinational path from out_ready.
- A push and a pop in the same cycle leave count unchanged. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_pc/out_instr: entry[rp] when out_valid, otherwise 0 / 32'h0.
- Flush has priority over everything:
  - Next state is wp = rp = count = 0.
  - A concurrent push is discarded and a concurrent pop is ignored.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of two).
- Full/empty are determined from count, not from pointer comparison.
- An ignored push (full) or a pop attempt when empty has no effect: no overflow, no underflow, no error flag.
- Array contents are not reset; only pointers and count are.

## Timing
- Reset (rst low, asynchronous):
  - Immediately forces wp = rp = count = 0.
  - Outputs: out_valid = 0, out_pc = 0, out_instr = 32'h0, in_ready = 1, count = 0.
- Reset asserted mid-operation discards all entries. Operation resumes on the first rising edge after rst returns high.
- Push-to-output latency: 1 cycle. A word pushed at edge N is visible on out_* after edge N (first-word fall-through).
- Outputs are combinational from registered state plus array reads. There is no input-to-output combinational path.
- Flush takes effect at the edge on which it is sampled. out_valid is 0 in the following cycle.
- Sustained throughput is one word per cycle with in_valid = out_ready = 1 and 0 < count < DEPTH.

## Structure
- Shared package pipeline_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - default FQ_DEPTH = 4
  - a fetch_entry struct {pc, instr}, reused by the IF/ID pipeline register
- One natural sub-module: fq_ptr, a wrapping pointer counter with inputs clk, rst, inc, clr and output ptr. It is instantiated twice, for wp and rp.
- The count update is local logic in fetch_queue. The array is inferred registers; DEPTH is small.

## Test plan
- Reset: push 2 words, then pull rst low between edges → out_valid = 0, out_instr = 0, count = 0, in_ready = 1 immediately, without waiting for an edge.
- Fill/drain:
  - With out_ready = 0, push PC 0x0/0x4/0x8/0xC, instr 0x20080001..04 → count = 4, in_ready = 0.
  - A 5th push (PC 0x10) is ignored.
  - Then out_ready = 1 for 4 cycles → out_pc is 0x0, 0x4, 0x8, 0xC in order, and afterwards count = 0 and out_instr = 0.
- Simultaneous push/pop at count = 2 → count stays 2, and the head advances by one entry per cycle.
- Flush with in_valid = 1 and out_ready = 1 at count = 3 → next cycle count = 0 and out_valid = 0. The concurrent word never appears at the output.
- Wrap-around: stream 10 words (PC 0x0..0x24) with out_ready toggling every other cycle → the output sequence equals the input sequence with no loss or duplication, and count never exceeds 4.
- Empty pop: out_ready = 1, in_valid = 0 for 3 cycles from reset → count stays 0 and out_instr stays 32'h0.
